// File: rtl/fifo_rr_arbiter_if.sv
// ============================================================================
// Module   : fifo_rr_arbiter_if
// Brief    : Upstream pop / downstream write bundle for fifo_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_rr_arbiter_if #(
    parameter int DATA_W = 6
);
    logic [3:0]          in_empty;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_rd;
    logic                out_full;
    logic                out_almost_full;
    logic                out_wr;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          active_port;
    logic                err_arb;

    modport master (
        input  in_empty, in_data, out_full, out_almost_full,
        output in_rd, out_wr, out_data, active_port, err_arb
    );

    modport slave (
        output in_empty, in_data, out_full, out_almost_full,
        input  in_rd, out_wr, out_data, active_port, err_arb
    );
endinterface

`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
// ============================================================================
// Module   : fifo_rr_arbiter
// Brief    : Round-robin burst arbiter draining four upstream FIFOs into one
//            downstream FIFO with full/almost-full backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rr_arbiter #(
    parameter int DATA_W = 6,
    parameter int BURST  = 4
) (
    input  wire logic         clk,
    input  wire logic         RESET,
    fifo_rr_arbiter_if.master bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_grant = 2'd1;
    localparam logic [1:0] c_st_stall = 2'd2;
    localparam logic [3:0] c_burst_max = 4'(BURST);

    logic [1:0] r_state;
    logic [1:0] r_rr_ptr;
    logic [3:0] r_burst_cnt;
    logic [1:0] r_port;
    logic [1:0] r_active;
    logic       r_out_wr;
    logic       r_err;

    logic [1:0] w_state_nxt;
    logic [1:0] w_rr_nxt;
    logic [3:0] w_burst_nxt;
    logic [1:0] w_port_nxt;
    logic       w_pop;
    logic [1:0] w_pop_port;
    logic [2:0] w_srch_rr;
    logic [2:0] w_srch_rot;
    logic       w_can_issue;
    logic       w_cont;
    logic [3:0] w_rd;
    logic       w_err_now;

    logic [DATA_W-1:0] w_in_word [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_in_word[gi] = bus.in_data[gi*DATA_W +: DATA_W];
    end

    // Returns {found, port}: first non-empty port scanning upward from start.
    function automatic logic [2:0] f_search(input logic [3:0] empty, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (!empty[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_can_issue = !bus.out_full && !(r_out_wr && bus.out_almost_full);
    assign w_cont      = (r_burst_cnt < c_burst_max) && !bus.in_empty[r_port];

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state     <= c_st_idle;
            r_rr_ptr    <= 2'd0;
            r_burst_cnt <= 4'd0;
            r_port      <= 2'd0;
            r_active    <= 2'd0;
            r_out_wr    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_port      <= w_port_nxt;
            r_out_wr    <= w_pop;
            r_err       <= r_err | w_err_now;
            if (w_pop) r_active <= w_pop_port;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_burst_nxt = r_burst_cnt;
        w_port_nxt  = r_port;
        w_pop       = 1'b0;
        w_pop_port  = r_port;
        w_srch_rr   = f_search(bus.in_empty, r_rr_ptr);
        w_srch_rot  = f_search(bus.in_empty, r_port + 2'd1);

        case (r_state)
            c_st_idle: begin
                if (w_srch_rr[2]) begin
                    w_port_nxt = w_srch_rr[1:0];
                    if (w_can_issue) begin
                        w_pop       = 1'b1;
                        w_pop_port  = w_srch_rr[1:0];
                        w_burst_nxt = 4'd1;
                        w_state_nxt = c_st_grant;
                    end else begin
                        // Stall with an empty burst so resuming pops the winner first.
                        w_burst_nxt = 4'd0;
                        w_state_nxt = c_st_stall;
                    end
                end
            end
            c_st_grant, c_st_stall: begin
                if (w_cont) begin
                    if (w_can_issue) begin
                        w_pop       = 1'b1;
                        w_burst_nxt = r_burst_cnt + 4'd1;
                        w_state_nxt = c_st_grant;
                    end else begin
                        w_state_nxt = c_st_stall;
                    end
                end else if (w_srch_rot[2]) begin
                    if (w_can_issue) begin
                        w_rr_nxt    = r_port + 2'd1;
                        w_pop       = 1'b1;
                        w_pop_port  = w_srch_rot[1:0];
                        w_port_nxt  = w_srch_rot[1:0];
                        w_burst_nxt = 4'd1;
                        w_state_nxt = c_st_grant;
                    end else begin
                        w_state_nxt = c_st_stall;
                    end
                end else begin
                    w_rr_nxt    = r_port + 2'd1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase

        if (RESET) w_pop = 1'b0;
    end

    always_comb begin
        w_rd      = w_pop ? (4'b0001 << w_pop_port) : 4'b0000;
        w_err_now = (r_out_wr && bus.out_full) || (|(w_rd & bus.in_empty));
    end

    assign bus.in_rd       = w_rd;
    assign bus.out_wr      = r_out_wr;
    assign bus.out_data    = r_out_wr ? w_in_word[r_active] : '0;
    assign bus.active_port = r_active;
    assign bus.err_arb     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_rr_arbiter
// Brief    : Directed self-checking bench for fifo_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rr_arbiter;

    logic clk = 1'b0;
    logic RESET;
    logic force_ne;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    fifo_rr_arbiter_if #(.DATA_W(6)) bus ();

    fifo_rr_arbiter #(.DATA_W(6), .BURST(4)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO models: registered data_out, empty derived from pointers.
    logic [5:0] mem [4][64];
    int         head [4] = '{default: 0};
    int         tail [4] = '{default: 0};
    logic [5:0] dout [4] = '{default: 6'd0};

    always_comb begin
        for (int i = 0; i < 4; i++) bus.in_empty[i] = force_ne ? 1'b0 : (head[i] == tail[i]);
    end
    assign bus.in_data = {dout[3], dout[2], dout[1], dout[0]};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.in_rd[i] && head[i] != tail[i]) begin
                dout[i] <= mem[i][head[i]];
                head[i] <= head[i] + 1;
            end
        end
    end

    logic [5:0] wr_log [256];
    int         wr_cyc [256];
    int         pop_cyc [256];
    int         nw = 0;
    int         np = 0;

    always @(negedge clk) begin
        if (bus.out_wr === 1'b1 && nw < 256) begin
            wr_log[nw] <= bus.out_data;
            wr_cyc[nw] <= cyc;
            nw <= nw + 1;
        end
        if (bus.in_rd !== 4'b0000 && np < 256) begin
            pop_cyc[np] <= cyc;
            np <= np + 1;
        end
    end

    task automatic push(input int p, input logic [5:0] d);
        mem[p][tail[p]] = d;
        tail[p] = tail[p] + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nw0;
        int np0;
        logic [5:0] exp_w;

        RESET = 1'b1;
        force_ne = 1'b1;
        bus.out_full = 1'b0;
        bus.out_almost_full = 1'b0;

        // Reset with every port claiming data: no pops, no writes.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_in_rd", bus.in_rd, 4'b0000);
            chk("rst_out_wr", bus.out_wr, 1'b0);
            chk("rst_err", bus.err_arb, 1'b0);
        end
        chk("rst_out_data", bus.out_data, 6'h00);
        chk("rst_active", bus.active_port, 2'd0);
        #1;
        RESET = 1'b0;
        force_ne = 1'b0;

        // Single port 2 with three words.
        step();
        push(2, 6'h11); push(2, 6'h12); push(2, 6'h13);
        @(negedge clk); chk("p2_rd0", bus.in_rd, 4'b0100);
        step(); @(negedge clk);
        chk("p2_rd1", bus.in_rd, 4'b0100); chk("p2_wr0", bus.out_wr, 1'b1); chk("p2_d0", bus.out_data, 6'h11);
        step(); @(negedge clk);
        chk("p2_rd2", bus.in_rd, 4'b0100); chk("p2_d1", bus.out_data, 6'h12);
        step(); @(negedge clk);
        chk("p2_rd3", bus.in_rd, 4'b0000); chk("p2_wr2", bus.out_wr, 1'b1); chk("p2_d2", bus.out_data, 6'h13);
        step(); @(negedge clk);
        chk("p2_idle_wr", bus.out_wr, 1'b0); chk("p2_idle_rd", bus.in_rd, 4'b0000);

        // Pointer now at 3: port 3 first, then wrap to port 0.
        step();
        push(3, 6'h31); push(3, 6'h32); push(0, 6'h01); push(0, 6'h02);
        @(negedge clk); chk("wrap_rd0", bus.in_rd, 4'b1000);
        step(); @(negedge clk);
        chk("wrap_rd1", bus.in_rd, 4'b1000); chk("wrap_d0", bus.out_data, 6'h31);
        step(); @(negedge clk);
        chk("wrap_rd2", bus.in_rd, 4'b0001); chk("wrap_d1", bus.out_data, 6'h32);
        step(); @(negedge clk);
        chk("wrap_rd3", bus.in_rd, 4'b0001); chk("wrap_d2", bus.out_data, 6'h01);
        step(); @(negedge clk);
        chk("wrap_rd4", bus.in_rd, 4'b0000); chk("wrap_d3", bus.out_data, 6'h02);
        chk("wrap_active", bus.active_port, 2'd0);
        step(); @(negedge clk);
        chk("wrap_idle_wr", bus.out_wr, 1'b0);

        // Reset in the cycle after a pop; arbitration restarts at port 0.
        step();
        push(1, 6'h2A); push(1, 6'h2B); push(1, 6'h2C); push(3, 6'h3A);
        @(negedge clk); chk("rr_rd0", bus.in_rd, 4'b0010);
        step();
        RESET = 1'b1;
        push(0, 6'h05);
        @(negedge clk);
        chk("rr_rd_gated", bus.in_rd, 4'b0000); chk("rr_wr_pre", bus.out_wr, 1'b1);
        chk("rr_d_pre", bus.out_data, 6'h2A);
        step();
        RESET = 1'b0;
        @(negedge clk);
        chk("rr_wr_post", bus.out_wr, 1'b0); chk("rr_active", bus.active_port, 2'd0);
        chk("rr_restart", bus.in_rd, 4'b0001);
        step(); @(negedge clk);
        chk("rr_rd1", bus.in_rd, 4'b0010); chk("rr_d1", bus.out_data, 6'h05);
        step(); @(negedge clk);
        chk("rr_rd2", bus.in_rd, 4'b0010); chk("rr_d2", bus.out_data, 6'h2B);
        step(); @(negedge clk);
        chk("rr_rd3", bus.in_rd, 4'b1000); chk("rr_d3", bus.out_data, 6'h2C);
        step(); @(negedge clk);
        chk("rr_rd4", bus.in_rd, 4'b0000); chk("rr_d4", bus.out_data, 6'h3A);
        step(); @(negedge clk);
        chk("rr_idle_wr", bus.out_wr, 1'b0);

        // All four ports with eight words: two full rotations of 4-word bursts.
        step();
        nw0 = nw;
        np0 = np;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 8; k++) push(p, 6'((p << 3) | k));
        repeat (36) step();
        chk("all_pops", np - np0, 32);
        chk("all_writes", nw - nw0, 32);
        chk("all_pop_span", pop_cyc[np0 + 31] - pop_cyc[np0], 31);
        chk("all_wr_span", wr_cyc[nw0 + 31] - wr_cyc[nw0], 31);
        chk("all_latency", wr_cyc[nw0] - pop_cyc[np0], 1);
        for (int j = 0; j < 32; j++) begin
            exp_w = 6'((((j / 4) % 4) << 3) | ((j / 16) * 4 + (j % 4)));
            chk($sformatf("all_d%0d", j), wr_log[nw0 + j], exp_w);
        end

        // Backpressure: almost_full with a write pending, then full for 5 cycles.
        nw0 = nw;
        push(1, 6'h20); push(1, 6'h21); push(1, 6'h22);
        push(1, 6'h23); push(1, 6'h24); push(1, 6'h25);
        @(negedge clk); chk("bp_rd0", bus.in_rd, 4'b0010);
        step();
        bus.out_almost_full = 1'b1;
        @(negedge clk);
        chk("bp_af_rd", bus.in_rd, 4'b0000); chk("bp_af_wr", bus.out_wr, 1'b1);
        step();
        bus.out_almost_full = 1'b0;
        bus.out_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk($sformatf("bp_full_rd%0d", i), bus.in_rd, 4'b0000);
            chk($sformatf("bp_full_wr%0d", i), bus.out_wr, 1'b0);
        end
        step();
        bus.out_full = 1'b0;
        @(negedge clk); chk("bp_resume", bus.in_rd, 4'b0010);
        repeat (8) step();
        chk("bp_writes", nw - nw0, 6);
        for (int j = 0; j < 6; j++) chk($sformatf("bp_d%0d", j), wr_log[nw0 + j], 6'(6'h20 + j));
        chk("bp_active", bus.active_port, 2'd1);
        chk("final_err", bus.err_arb, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
